// File: rtl/adc_scan_if_pkg.sv
// Shared types and frame constants for the AD7265-class scanning ADC interface.
// Frame layout: 16 sclk cycles, the first two carry leading zeros.
package adc_scan_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUIET,
        ST_CONV,
        ST_STORE
    } adc_scan_state_t;

    localparam int ADC_FRAME_LEN  = 16;
    localparam int ADC_LEAD_ZEROS = 2;

    // True while frame bit index k carries a data bit rather than a leading zero or tail.
    function automatic logic in_sample_window(input logic [3:0] k, input int dw);
        return (int'(k) >= ADC_LEAD_ZEROS) && (int'(k) < ADC_LEAD_ZEROS + dw);
    endfunction

endpackage

// File: rtl/adc_scan_if_if.sv
// Bundle of scan control, ADC pin and result signals between the scanner and its neighbours.
// slave = the scanner itself, master = the bus/pin side driving it.
interface adc_scan_if_if #(
    parameter int DW = 12
);
    logic          start;
    logic          cont_en;
    logic          rng_sel;
    logic          sgl_sel;
    logic [DW-1:0] thresh;
    logic          douta;
    logic          doutb;

    logic          adc_sclk_en;
    logic [2:0]    adc_addr;
    logic          ncs;
    logic          rng;
    logic          sgl;
    logic          busy;
    logic          res_valid;
    logic [2:0]    res_ch;
    logic [DW-1:0] res_a;
    logic [DW-1:0] res_b;
    logic [DW:0]   res_sum;
    logic          scan_done;
    logic          over_thresh;

    modport slave (
        input  start, cont_en, rng_sel, sgl_sel, thresh, douta, doutb,
        output adc_sclk_en, adc_addr, ncs, rng, sgl, busy,
               res_valid, res_ch, res_a, res_b, res_sum, scan_done, over_thresh
    );

    modport master (
        output start, cont_en, rng_sel, sgl_sel, thresh, douta, doutb,
        input  adc_sclk_en, adc_addr, ncs, rng, sgl, busy,
               res_valid, res_ch, res_a, res_b, res_sum, scan_done, over_thresh
    );
endinterface

// File: rtl/adc_scan_if_dual_shift_rx.sv
// Two MSB-first serial receivers capturing douta/doutb in lockstep while sample_en is high.
module adc_dual_shift_rx #(
    parameter int DW = 12
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          sample_en,
    input  logic          douta,
    input  logic          doutb,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b
);

    logic [DW-1:0] shift_a_q, shift_a_d;
    logic [DW-1:0] shift_b_q, shift_b_d;

    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        if (sample_en) begin
            shift_a_d = {shift_a_q[DW-2:0], douta};
            shift_b_d = {shift_b_q[DW-2:0], doutb};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
        end
    end

    assign data_a = shift_a_q;
    assign data_b = shift_b_q;

endmodule

// File: rtl/adc_scan_if.sv
// Scanning, averaging front end for an AD7265-class dual simultaneous-sampling ADC.
// Optional over-threshold flag is built when ADC_SCAN_THRESH_EN is defined.
module adc_scan_if
    import adc_scan_if_pkg::*;
#(
    parameter int NCH      = 6,
    parameter int DW       = 12,
    parameter int AVG_LOG2 = 0,
    parameter int QUIET    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          soft_reset,
    adc_scan_if_if.slave  bus
);

    localparam int         AW         = DW + AVG_LOG2;
    localparam logic [3:0] AVG_LAST   = 4'((1 << AVG_LOG2) - 1);
    localparam logic [2:0] CH_LAST    = 3'(NCH - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);
    localparam logic [7:0] K_LAST     = 8'(ADC_FRAME_LEN - 1);

    logic rst;
    assign rst = reset | soft_reset;

    adc_scan_state_t state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [2:0]      ch_q, ch_d;
    logic [3:0]      avg_q, avg_d;
    logic [AW-1:0]   acc_a_q, acc_a_d;
    logic [AW-1:0]   acc_b_q, acc_b_d;
    logic            rng_q, rng_d;
    logic            sgl_q, sgl_d;
    logic            res_valid_q, res_valid_d;
    logic            scan_done_q, scan_done_d;
    logic [2:0]      res_ch_q, res_ch_d;
    logic [DW-1:0]   res_a_q, res_a_d;
    logic [DW-1:0]   res_b_q, res_b_d;
    logic [DW:0]     res_sum_q, res_sum_d;

    logic            store_result;
    logic            chan_last;
    logic            scan_begin;
    logic            sample_en;
    logic [DW-1:0]   sample_a, sample_b;
    logic [AW-1:0]   sum_a, sum_b;
    logic [DW-1:0]   avg_a, avg_b;

    adc_dual_shift_rx #(.DW(DW)) u_rx (
        .clock     (clock),
        .clear     (rst),
        .sample_en (sample_en),
        .douta     (bus.douta),
        .doutb     (bus.doutb),
        .data_a    (sample_a),
        .data_b    (sample_b)
    );

    assign store_result = (avg_q == AVG_LAST);
    assign chan_last    = (ch_q == CH_LAST);
    // A scan begins either from an idle start or as the automatic restart after the last result.
    assign scan_begin   = ((state_q == ST_IDLE) && bus.start) ||
                          ((state_q == ST_STORE) && store_result && chan_last && bus.cont_en);

    assign sum_a = acc_a_q + AW'(sample_a);
    assign sum_b = acc_b_q + AW'(sample_b);
    assign avg_a = sum_a[AVG_LOG2 +: DW];
    assign avg_b = sum_b[AVG_LOG2 +: DW];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_QUIET;
            ST_QUIET: if (timer_q == QUIET_LAST) state_d = ST_CONV;
            ST_CONV:  if (timer_q == K_LAST) state_d = ST_STORE;
            ST_STORE: begin
                if (store_result && chan_last && !bus.cont_en) state_d = ST_IDLE;
                else                                           state_d = ST_QUIET;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d     = timer_q;
        ch_d        = ch_q;
        avg_d       = avg_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        rng_d       = rng_q;
        sgl_d       = sgl_q;
        res_valid_d = 1'b0;
        scan_done_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_sum_d   = res_sum_q;
        case (state_q)
            ST_QUIET: timer_d = (timer_q == QUIET_LAST) ? 8'd0 : timer_q + 8'd1;
            ST_CONV:  timer_d = (timer_q == K_LAST) ? 8'd0 : timer_q + 8'd1;
            ST_STORE: begin
                timer_d = 8'd0;
                if (!store_result) begin
                    avg_d   = avg_q + 4'd1;
                    acc_a_d = sum_a;
                    acc_b_d = sum_b;
                end else begin
                    avg_d       = 4'd0;
                    acc_a_d     = '0;
                    acc_b_d     = '0;
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    res_a_d     = avg_a;
                    res_b_d     = avg_b;
                    res_sum_d   = {1'b0, avg_a} + {1'b0, avg_b};
                    if (chan_last) begin
                        scan_done_d = 1'b1;
                        ch_d        = 3'd0;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
        if (scan_begin) begin
            timer_d = 8'd0;
            ch_d    = 3'd0;
            avg_d   = 4'd0;
            acc_a_d = '0;
            acc_b_d = '0;
            rng_d   = bus.rng_sel;
            sgl_d   = bus.sgl_sel;
        end
    end

    always_comb begin
        bus.ncs         = 1'b1;
        bus.adc_sclk_en = 1'b0;
        sample_en       = 1'b0;
        if (state_q == ST_CONV) begin
            bus.ncs         = 1'b0;
            bus.adc_sclk_en = 1'b1;
            sample_en       = in_sample_window(timer_q[3:0], DW);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            ch_q        <= '0;
            avg_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            rng_q       <= 1'b0;
            sgl_q       <= 1'b0;
            res_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
            res_ch_q    <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ch_q        <= ch_d;
            avg_q       <= avg_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            rng_q       <= rng_d;
            sgl_q       <= sgl_d;
            res_valid_q <= res_valid_d;
            scan_done_q <= scan_done_d;
            res_ch_q    <= res_ch_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_sum_q   <= res_sum_d;
        end
    end

`ifdef ADC_SCAN_THRESH_EN
    logic over_q, over_d;
    logic over_hit;

    // A restart clears the flag but the result produced in that same cycle still counts.
    always_comb begin
        over_hit = (state_q == ST_STORE) && store_result &&
                   ((avg_a > bus.thresh) || (avg_b > bus.thresh));
        over_d   = (scan_begin ? 1'b0 : over_q) | over_hit;
    end

    always_ff @(posedge clock) begin
        if (rst) over_q <= 1'b0;
        else     over_q <= over_d;
    end

    assign bus.over_thresh = over_q;
`else
    logic thresh_unused;
    assign thresh_unused   = ^bus.thresh;
    assign bus.over_thresh = 1'b0;
`endif

    assign bus.adc_addr  = ch_q;
    assign bus.rng       = rng_q;
    assign bus.sgl       = sgl_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_a     = res_a_q;
    assign bus.res_b     = res_b_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_adc_scan_if.sv
// Directed bench for adc_scan_if: a 6-channel unaveraged instance and a 2-channel 4x-averaged one,
// each fed by a behavioural AD7265 model. Threshold checks follow ADC_SCAN_THRESH_EN.
module tb_adc_scan_if;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset0;
    logic soft_reset1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    adc_scan_if_if #(.DW(12)) bus0 ();
    adc_scan_if_if #(.DW(12)) bus1 ();

    adc_scan_if #(.NCH(6), .DW(12), .AVG_LOG2(0), .QUIET(2)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset0),
        .bus        (bus0)
    );

    adc_scan_if #(.NCH(2), .DW(12), .AVG_LOG2(2), .QUIET(2)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset1),
        .bus        (bus1)
    );

    logic [11:0] tab_a [0:7] = '{12'h012, 12'h345, 12'h678, 12'h9ab, 12'hcde, 12'hf01, 12'h000, 12'h000};
    logic [11:0] tab_b [0:7] = '{12'hfed, 12'hcba, 12'h987, 12'h654, 12'h321, 12'h0fe, 12'h000, 12'h000};
    logic [11:0] thr = 12'hf00;

    function automatic logic bit_at(input logic [11:0] w, input int k);
        if (k >= 2 && k < 14) return w[13 - k];
        return 1'b0;
    endfunction

    function automatic logic [11:0] word1(input bit is_b, input logic [2:0] addr, input int frm);
        if (addr == 3'd0) begin
            if (is_b) return (frm % 2 == 1) ? 12'h102 : 12'h100;
            return (frm % 2 == 1) ? 12'h346 : 12'h344;
        end
        return is_b ? 12'hfff : 12'h800;
    endfunction

    // ADC models: present bit k of the addressed word during the k-th low-ncs cycle.
    int k0 = 0;
    always @(negedge clock) begin
        if (!bus0.ncs) begin
            bus0.douta = bit_at(tab_a[bus0.adc_addr], k0);
            bus0.doutb = bit_at(tab_b[bus0.adc_addr], k0);
            k0 = k0 + 1;
        end else begin
            k0 = 0;
            bus0.douta = 1'b0;
            bus0.doutb = 1'b0;
        end
    end

    int k1 = 0;
    int frm1 = 0;
    always @(negedge clock) begin
        if (!bus1.ncs) begin
            bus1.douta = bit_at(word1(1'b0, bus1.adc_addr, frm1), k1);
            bus1.doutb = bit_at(word1(1'b1, bus1.adc_addr, frm1), k1);
            if (k1 == 15) frm1 = frm1 + 1;
            k1 = k1 + 1;
        end else begin
            k1 = 0;
            bus1.douta = 1'b0;
            bus1.doutb = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Sets the scan options and pulses start; returns at the first cycle of the scan.
    task automatic applyStimulus(input bit rng_sel, input bit sgl_sel, input bit cont_en);
        @(negedge clock);
        bus0.rng_sel = rng_sel;
        bus0.sgl_sel = sgl_sel;
        bus0.cont_en = cont_en;
        bus0.start   = 1'b1;
        @(negedge clock);
        bus0.start   = 1'b0;
    endtask

    // Follows dut0 from the first scan cycle until busy drops, checking every result slot.
    task automatic runScan0(input int max_cyc, input int drop_at, input int poke_at, input int n_scans,
                            output int busy_cycles, output int n_valid);
        int    cyc;
        int    ch;
        bit    hit;
        bit    over_exp = 1'b0;
        logic [12:0] sum_exp;
        n_valid = 0;
        for (cyc = 0; cyc < max_cyc; cyc++) begin
            if (cyc == 0) checkOutput("over_clr_at_start", {31'd0, bus0.over_thresh}, 32'd0);
            if (cyc == drop_at) bus0.cont_en = 1'b0;
            if (cyc == poke_at) begin
                bus0.start   = 1'b1;
                bus0.rng_sel = ~bus0.rng_sel;
            end
            if (cyc == poke_at + 1) bus0.start = 1'b0;
            if (cyc > 0 && cyc % 19 == 0) begin
                ch      = n_valid % 6;
                sum_exp = {1'b0, tab_a[ch]} + {1'b0, tab_b[ch]};
                checkOutput("res_valid", {31'd0, bus0.res_valid}, 32'd1);
                checkOutput("res_ch", {29'd0, bus0.res_ch}, ch);
                checkOutput("res_a", {20'd0, bus0.res_a}, {20'd0, tab_a[ch]});
                checkOutput("res_b", {20'd0, bus0.res_b}, {20'd0, tab_b[ch]});
                checkOutput("res_sum", {19'd0, bus0.res_sum}, {19'd0, sum_exp});
                checkOutput("scan_done", {31'd0, bus0.scan_done}, (ch == 5) ? 32'd1 : 32'd0);
`ifdef ADC_SCAN_THRESH_EN
                hit = (tab_a[ch] > thr) || (tab_b[ch] > thr);
                if (ch == 5 && (n_valid / 6) < n_scans - 1) over_exp = hit;
                else                                        over_exp = over_exp | hit;
`else
                hit = 1'b0;
`endif
                checkOutput("over_thresh", {31'd0, bus0.over_thresh}, {31'd0, over_exp});
                n_valid++;
            end else if (bus0.res_valid || bus0.scan_done) begin
                checkOutput("stray_strobe", {30'd0, bus0.res_valid, bus0.scan_done}, 32'd0);
            end
            if (!bus0.busy) break;
            @(negedge clock);
        end
        checkOutput("scan_timeout", (cyc < max_cyc) ? 32'd1 : 32'd0, 32'd1);
        busy_cycles = cyc;
    endtask

    int busy_cycles;
    int n_valid;

    logic [11:0] exp1_a [0:1] = '{12'h345, 12'h800};
    logic [11:0] exp1_b [0:1] = '{12'h101, 12'hfff};

    initial begin
        reset       = 1'b1;
        soft_reset0 = 1'b0;
        soft_reset1 = 1'b0;
        bus0.start = 1'b0; bus0.cont_en = 1'b0; bus0.rng_sel = 1'b0; bus0.sgl_sel = 1'b0;
        bus1.start = 1'b0; bus1.cont_en = 1'b0; bus1.rng_sel = 1'b0; bus1.sgl_sel = 1'b0;
        bus0.thresh = thr;
        bus1.thresh = thr;
        repeat (3) @(negedge clock);

        checkOutput("rst_ncs", {31'd0, bus0.ncs}, 32'd1);
        checkOutput("rst_sclk_en", {31'd0, bus0.adc_sclk_en}, 32'd0);
        checkOutput("rst_addr", {29'd0, bus0.adc_addr}, 32'd0);
        checkOutput("rst_rng_sgl", {30'd0, bus0.rng, bus0.sgl}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus0.busy}, 32'd0);
        checkOutput("rst_strobes", {30'd0, bus0.res_valid, bus0.scan_done}, 32'd0);
        checkOutput("rst_results", {bus0.res_a, bus0.res_b, 5'd0, bus0.res_ch}, 32'd0);
        checkOutput("rst_sum", {19'd0, bus0.res_sum}, 32'd0);
        checkOutput("rst_over", {31'd0, bus0.over_thresh}, 32'd0);
        reset = 1'b0;

        $display("[TB] single scan, sgl latched");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("busy_rise", {31'd0, bus0.busy}, 32'd1);
        checkOutput("latch_rng_sgl_1", {30'd0, bus0.rng, bus0.sgl}, 32'd1);
        runScan0(300, -1, -1, 1, busy_cycles, n_valid);
        checkOutput("scan1_busy_len", busy_cycles, 32'd114);
        checkOutput("scan1_results", n_valid, 32'd6);

        $display("[TB] start and rng_sel poked mid-scan");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("latch_rng_sgl_2", {30'd0, bus0.rng, bus0.sgl}, 32'd2);
        runScan0(300, -1, 50, 1, busy_cycles, n_valid);
        checkOutput("poke_busy_len", busy_cycles, 32'd114);
        checkOutput("poke_results", n_valid, 32'd6);
        checkOutput("rng_held", {31'd0, bus0.rng}, 32'd1);

        $display("[TB] soft reset during CONV k=7 of channel 2");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rng_relatched", {31'd0, bus0.rng}, 32'd0);
        repeat (47) @(negedge clock);
        checkOutput("pre_rst_conv", {30'd0, bus0.ncs, bus0.adc_sclk_en}, 32'd1);
        checkOutput("pre_rst_ch", {29'd0, bus0.res_ch}, 32'd1);
        checkOutput("pre_rst_a_held", {20'd0, bus0.res_a}, 32'h345);
        soft_reset0 = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_pins", {30'd0, bus0.ncs, bus0.adc_sclk_en}, 32'd2);
        checkOutput("mid_rst_busy", {31'd0, bus0.busy}, 32'd0);
        checkOutput("mid_rst_results", {bus0.res_a, bus0.res_b, 5'd0, bus0.res_ch}, 32'd0);
        checkOutput("mid_rst_strobe", {31'd0, bus0.res_valid}, 32'd0);
        soft_reset0 = 1'b0;

        $display("[TB] full scan after reset");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runScan0(300, -1, -1, 1, busy_cycles, n_valid);
        checkOutput("post_rst_busy_len", busy_cycles, 32'd114);
        checkOutput("post_rst_results", n_valid, 32'd6);

        $display("[TB] continuous scan, cont_en dropped in second scan");
        applyStimulus(1'b0, 1'b0, 1'b1);
        runScan0(400, 150, -1, 2, busy_cycles, n_valid);
        checkOutput("cont_busy_len", busy_cycles, 32'd228);
        checkOutput("cont_results", n_valid, 32'd12);

        $display("[TB] averaged instance");
        @(negedge clock);
        bus1.start = 1'b1;
        @(negedge clock);
        bus1.start = 1'b0;
        n_valid = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            busy_cycles = cyc;
            if (cyc > 0 && cyc % 76 == 0) begin
                if (n_valid < 2) begin
                    checkOutput("avg_valid", {31'd0, bus1.res_valid}, 32'd1);
                    checkOutput("avg_ch", {29'd0, bus1.res_ch}, n_valid);
                    checkOutput("avg_a", {20'd0, bus1.res_a}, {20'd0, exp1_a[n_valid]});
                    checkOutput("avg_b", {20'd0, bus1.res_b}, {20'd0, exp1_b[n_valid]});
                    checkOutput("avg_sum", {19'd0, bus1.res_sum},
                                {19'd0, {1'b0, exp1_a[n_valid]} + {1'b0, exp1_b[n_valid]}});
                end
                n_valid++;
            end else if (bus1.res_valid) begin
                checkOutput("avg_stray_valid", {31'd0, bus1.res_valid}, 32'd0);
            end
            if (!bus1.busy) break;
            @(negedge clock);
        end
        checkOutput("avg_busy_len", busy_cycles, 32'd152);
        checkOutput("avg_results", n_valid, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
